// File: rtl/pipe_dbg_pkg.sv
// Shared command and state encodings for the pipeline step/trace controller.
package pipe_dbg_pkg;

  localparam logic [1:0] MODE_STEP     = 2'd0;
  localparam logic [1:0] MODE_RUN_N    = 2'd1;
  localparam logic [1:0] MODE_RUN_FREE = 2'd2;
  localparam logic [1:0] MODE_HALT     = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead trace FIFO. When OVERWRITE is set, a write into a full FIFO drops
// the oldest entry and raises the sticky overflow flag.
module trace_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter bit OVERWRITE = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [LW-1:0]     count;
  logic              pop;
  logic              push;
  logic              drop;

  assign empty    = (count == '0);
  assign full     = (count == LW'(DEPTH));
  assign level    = count;
  assign pop      = rd & ~empty;
  assign push     = wr & (pop | ~full | OVERWRITE);
  // A dropping write replaces the oldest slot, so both pointers move and the level holds.
  assign drop     = wr & ~pop & full & OVERWRITE;
  assign rd_data  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop | drop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push & ~pop & ~drop) begin
        count <= count + 1'b1;
      end else if (pop & ~push) begin
        count <= count - 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipeline_step_trace.sv
// Debug clock-enable generator for the pipeline core (step / run-N / free-run)
// with a trace FIFO capturing every enabled, valid writeback word.
module pipeline_step_trace
  import pipe_dbg_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 16,
  parameter int CNT_W        = 16,
  parameter bit STOP_ON_FULL = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_mode,
  input  logic [CNT_W-1:0]       cmd_count,
  output logic                   pipe_en,
  input  logic                   wb_valid,
  input  logic [DATA_W-1:0]      wb_data,
  input  logic                   trace_rd,
  output logic [DATA_W-1:0]      trace_data,
  output logic                   trace_empty,
  output logic                   trace_full,
  output logic [$clog2(DEPTH):0] trace_level,
  output logic                   overflow,
  output logic                   busy,
  output logic [CNT_W-1:0]       cycle_count
);

  state_t           state;
  logic             free_run;
  logic [CNT_W-1:0] remaining;
  logic             accept;
  logic             stall;
  logic             capture;

  // While running, only HALT may be accepted; everything else waits for IDLE.
  assign cmd_ready = (state == ST_IDLE) | (cmd_mode == MODE_HALT);
  assign accept    = cmd_valid & cmd_ready;
  assign stall     = STOP_ON_FULL & trace_full & ~trace_rd;
  assign pipe_en   = (state == ST_RUN) & ~stall;
  assign busy      = (state == ST_RUN);
  assign capture   = pipe_en & wb_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      free_run    <= 1'b0;
      remaining   <= '0;
      cycle_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (cmd_mode)
              MODE_STEP: begin
                state       <= ST_RUN;
                remaining   <= CNT_W'(1);
                free_run    <= 1'b0;
                cycle_count <= '0;
              end
              MODE_RUN_N: begin
                if (cmd_count != '0) begin
                  state       <= ST_RUN;
                  remaining   <= cmd_count;
                  free_run    <= 1'b0;
                  cycle_count <= '0;
                end
              end
              MODE_RUN_FREE: begin
                state       <= ST_RUN;
                remaining   <= '0;
                free_run    <= 1'b1;
                cycle_count <= '0;
              end
              default: begin
              end
            endcase
          end
        end
        ST_RUN: begin
          // Stalled cycles neither count nor consume the remaining budget.
          if (pipe_en) begin
            if (cycle_count != {CNT_W{1'b1}}) begin
              cycle_count <= cycle_count + 1'b1;
            end
            if (!free_run) begin
              remaining <= remaining - 1'b1;
              if (remaining == CNT_W'(1)) begin
                state <= ST_IDLE;
              end
            end
          end
          if (accept) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  trace_fifo #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .OVERWRITE(!STOP_ON_FULL)
  ) u_trace_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (capture),
    .wr_data (wb_data),
    .rd      (trace_rd),
    .rd_data (trace_data),
    .empty   (trace_empty),
    .full    (trace_full),
    .level   (trace_level),
    .overflow(overflow)
  );

endmodule

// File: tb/tb_pipeline_step_trace.sv
// Bench for pipeline_step_trace: dut0 stalls when the trace is full, dut1 overwrites.
// A queue-based model is compared against both DUTs on every falling edge.
module tb_pipeline_step_trace;
  import pipe_dbg_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CW    = 16;
  localparam int LW    = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0]          cmd_valid, cmd_ready, pipe_en, wb_valid, trace_rd;
  logic [1:0]          trace_empty, trace_full, overflow, busy;
  logic [1:0][1:0]     cmd_mode;
  logic [1:0][CW-1:0]  cmd_count, cycle_count;
  logic [1:0][DW-1:0]  wb_data, trace_data;
  logic [1:0][LW-1:0]  trace_level;

  always #5 clk = ~clk;

  pipeline_step_trace #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW), .STOP_ON_FULL(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_mode(cmd_mode[0]), .cmd_count(cmd_count[0]), .pipe_en(pipe_en[0]),
    .wb_valid(wb_valid[0]), .wb_data(wb_data[0]), .trace_rd(trace_rd[0]),
    .trace_data(trace_data[0]), .trace_empty(trace_empty[0]), .trace_full(trace_full[0]),
    .trace_level(trace_level[0]), .overflow(overflow[0]), .busy(busy[0]),
    .cycle_count(cycle_count[0]));

  pipeline_step_trace #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW), .STOP_ON_FULL(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_mode(cmd_mode[1]), .cmd_count(cmd_count[1]), .pipe_en(pipe_en[1]),
    .wb_valid(wb_valid[1]), .wb_data(wb_data[1]), .trace_rd(trace_rd[1]),
    .trace_data(trace_data[1]), .trace_empty(trace_empty[1]), .trace_full(trace_full[1]),
    .trace_level(trace_level[1]), .overflow(overflow[1]), .busy(busy[1]),
    .cycle_count(cycle_count[1]));

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  // Model state: running flag, free-run flag, remaining budget, counter, sticky loss.
  bit  stop_on_full [2] = '{1'b1, 1'b0};
  bit  m_run [2];
  bit  m_free [2];
  int  m_rem [2];
  int  m_cc [2];
  bit  m_ovf [2];
  int  nv [2];
  int  en_count [2];
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] pop0[$];
  logic [31:0] pop1[$];

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d: got %0h, expected %0h", name, k, act, exp);
    end
  endtask

  function automatic int q_size(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [31:0] q_front(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  task automatic q_push(input int k, input logic [31:0] v);
    if (k == 0) q0.push_back(v);
    else q1.push_back(v);
  endtask

  task automatic q_pop(input int k);
    if (k == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 1'b0;
      m_free[k] = 1'b0;
      m_rem[k] = 0;
      m_cc[k] = 0;
      m_ovf[k] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  // Compare one DUT against the model for the current cycle, then advance the model.
  task automatic check_output(input int k);
    int size;
    bit full, ready, acc, stall, en, wr, pop, was_run;
    logic [31:0] front;
    size  = q_size(k);
    full  = (size == DEPTH);
    front = (size > 0) ? q_front(k) : 32'h0;
    ready = !m_run[k] || (cmd_mode[k] == MODE_HALT);
    acc   = cmd_valid[k] && ready;
    stall = stop_on_full[k] && full && !trace_rd[k];
    en    = m_run[k] && !stall;

    check("cmd_ready",   k, 32'(cmd_ready[k]),   32'(ready));
    check("pipe_en",     k, 32'(pipe_en[k]),     32'(en));
    check("busy",        k, 32'(busy[k]),        32'(m_run[k]));
    check("cycle_count", k, 32'(cycle_count[k]), m_cc[k]);
    check("trace_level", k, 32'(trace_level[k]), size);
    check("trace_empty", k, 32'(trace_empty[k]), 32'(size == 0));
    check("trace_full",  k, 32'(trace_full[k]),  32'(full));
    check("overflow",    k, 32'(overflow[k]),    32'(m_ovf[k]));
    check("trace_data",  k, trace_data[k],       front);

    if (pipe_en[k]) en_count[k]++;
    if (trace_rd[k] && !trace_empty[k]) begin
      if (k == 0) pop0.push_back(trace_data[k]);
      else pop1.push_back(trace_data[k]);
    end

    wr  = en && wb_valid[k];
    pop = trace_rd[k] && (size > 0);
    if (pop) q_pop(k);
    if (wr) begin
      if (!pop && full) begin
        q_pop(k);
        m_ovf[k] = 1'b1;
      end
      q_push(k, wb_data[k]);
      nv[k]++;
    end

    was_run = m_run[k];
    if (was_run) begin
      if (en) begin
        if (m_cc[k] < 65535) m_cc[k]++;
        if (!m_free[k]) begin
          if (m_rem[k] == 1) m_run[k] = 1'b0;
          m_rem[k]--;
        end
      end
      if (acc) m_run[k] = 1'b0;
    end else if (acc) begin
      if (cmd_mode[k] == MODE_STEP) begin
        m_run[k] = 1'b1; m_rem[k] = 1; m_free[k] = 1'b0; m_cc[k] = 0;
      end else if (cmd_mode[k] == MODE_RUN_N && cmd_count[k] != 0) begin
        m_run[k] = 1'b1; m_rem[k] = int'(cmd_count[k]); m_free[k] = 1'b0; m_cc[k] = 0;
      end else if (cmd_mode[k] == MODE_RUN_FREE) begin
        m_run[k] = 1'b1; m_rem[k] = 0; m_free[k] = 1'b1; m_cc[k] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (checking && rst_n) begin
      for (int k = 0; k < 2; k++) check_output(k);
    end
  end

  task automatic apply_stimulus(input bit v, input logic [1:0] mode, input logic [15:0] cnt,
                                input bit wbv, input logic [31:0] wbd, input bit rd);
    for (int k = 0; k < 2; k++) begin
      cmd_valid[k] = v;
      cmd_mode[k]  = mode;
      cmd_count[k] = cnt;
      wb_valid[k]  = wbv;
      wb_data[k]   = wbd;
      trace_rd[k]  = rd;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ok0, ok1;
    apply_stimulus(1'b0, MODE_STEP, 16'd0, 1'b0, 32'h0, 1'b0);
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_pipe_en", k, 32'(pipe_en[k]), 32'h0);
      check("rst_busy", k, 32'(busy[k]), 32'h0);
      check("rst_cycle_count", k, 32'(cycle_count[k]), 32'h0);
      check("rst_empty", k, 32'(trace_empty[k]), 32'h1);
      check("rst_level", k, 32'(trace_level[k]), 32'h0);
      check("rst_data", k, trace_data[k], 32'h0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checking = 1'b1;

    // Single step captures one word
    en_count = '{0, 0};
    apply_stimulus(1'b1, MODE_STEP, 16'd0, 1'b1, 32'h0000_00AA, 1'b0);
    tick();
    apply_stimulus(1'b0, MODE_STEP, 16'd0, 1'b1, 32'h0000_00AA, 1'b0);
    tick();
    apply_stimulus(1'b0, MODE_STEP, 16'd0, 1'b0, 32'h0, 1'b0);
    repeat (2) tick();
    for (int k = 0; k < 2; k++) begin
      check("step_pulses", k, en_count[k], 32'd1);
      check("step_level", k, 32'(trace_level[k]), 32'd1);
      check("step_data", k, trace_data[k], 32'h0000_00AA);
      check("step_cycles", k, 32'(cycle_count[k]), 32'd1);
      check("step_busy", k, 32'(busy[k]), 32'd0);
    end
    apply_stimulus(1'b0, MODE_STEP, 16'd0, 1'b0, 32'h0, 1'b1);
    tick();

    // RUN_N 5 with alternating valid writebacks
    en_count = '{0, 0};
    apply_stimulus(1'b1, MODE_RUN_N, 16'd5, 1'b0, 32'h0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0, MODE_STEP, 16'd0, (i % 2) == 0, 32'h10 + i, 1'b0);
      tick();
    end
    apply_stimulus(1'b0, MODE_STEP, 16'd0, 1'b0, 32'h0, 1'b0);
    repeat (2) tick();
    for (int k = 0; k < 2; k++) begin
      check("run5_pulses", k, en_count[k], 32'd5);
      check("run5_level", k, 32'(trace_level[k]), 32'd3);
      check("run5_cycles", k, 32'(cycle_count[k]), 32'd5);
      check("run5_head", k, trace_data[k], 32'h10);
    end

    // RUN_N 0 is a no-op
    en_count = '{0, 0};
    apply_stimulus(1'b1, MODE_RUN_N, 16'd0, 1'b1, 32'h99, 1'b0);
    tick();
    apply_stimulus(1'b0, MODE_STEP, 16'd0, 1'b0, 32'h0, 1'b0);
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      check("run0_pulses", k, en_count[k], 32'd0);
      check("run0_cycles", k, 32'(cycle_count[k]), 32'd5);
      check("run0_busy", k, 32'(busy[k]), 32'd0);
    end

    apply_stimulus(1'b0, MODE_STEP, 16'd0, 1'b0, 32'h0, 1'b1);
    repeat (4) tick();
    apply_stimulus(1'b0, MODE_STEP, 16'd0, 1'b0, 32'h0, 1'b0);
    tick();

    // Free run halted on the seventh enabled cycle
    en_count = '{0, 0};
    apply_stimulus(1'b1, MODE_RUN_FREE, 16'd0, 1'b0, 32'h0, 1'b0);
    tick();
    for (int i = 1; i <= 7; i++) begin
      if (i == 3) begin
        apply_stimulus(1'b1, MODE_STEP, 16'd0, 1'b0, 32'h0, 1'b0);
        #1;
        for (int k = 0; k < 2; k++) check("ready_step_in_run", k, 32'(cmd_ready[k]), 32'd0);
      end else if (i == 7) begin
        apply_stimulus(1'b1, MODE_HALT, 16'd0, 1'b0, 32'h0, 1'b0);
        #1;
        for (int k = 0; k < 2; k++) check("ready_halt_in_run", k, 32'(cmd_ready[k]), 32'd1);
      end else begin
        apply_stimulus(1'b0, MODE_STEP, 16'd0, 1'b0, 32'h0, 1'b0);
      end
      tick();
    end
    apply_stimulus(1'b0, MODE_STEP, 16'd0, 1'b0, 32'h0, 1'b0);
    repeat (2) tick();
    for (int k = 0; k < 2; k++) begin
      check("free_pulses", k, en_count[k], 32'd7);
      check("free_cycles", k, 32'(cycle_count[k]), 32'd7);
      check("free_busy", k, 32'(busy[k]), 32'd0);
    end

    // Fill the trace with 1..20: dut0 stalls at full, dut1 overwrites
    nv = '{1, 1};
    apply_stimulus(1'b1, MODE_RUN_FREE, 16'd0, 1'b1, 32'h0, 1'b0);
    tick();
    for (int i = 1; i <= 20; i++) begin
      apply_stimulus(1'b0, MODE_STEP, 16'd0, 1'b1, 32'h0, 1'b0);
      if (i == 20) begin
        cmd_valid[1] = 1'b1;
        cmd_mode[1]  = MODE_HALT;
      end
      for (int k = 0; k < 2; k++) wb_data[k] = 32'(nv[k]);
      tick();
    end
    apply_stimulus(1'b0, MODE_STEP, 16'd0, 1'b1, 32'h0, 1'b0);
    for (int k = 0; k < 2; k++) wb_data[k] = 32'(nv[k]);
    #1;
    check("full_stall_pipe_en", 0, 32'(pipe_en[0]), 32'd0);
    check("full_stall_full", 0, 32'(trace_full[0]), 32'd1);
    check("full_stall_level", 0, 32'(trace_level[0]), 32'd16);
    check("full_stall_head", 0, trace_data[0], 32'd1);
    check("ovw_overflow", 1, 32'(overflow[1]), 32'd1);
    check("ovw_level", 1, 32'(trace_level[1]), 32'd16);
    check("ovw_head", 1, trace_data[1], 32'd5);
    check("ovw_busy", 1, 32'(busy[1]), 32'd0);

    pop0.delete();
    pop1.delete();
    for (int i = 1; i <= 20; i++) begin
      apply_stimulus(1'b0, MODE_STEP, 16'd0, 1'b1, 32'h0, 1'b1);
      if (i == 4) begin
        cmd_valid[0] = 1'b1;
        cmd_mode[0]  = MODE_HALT;
      end
      for (int k = 0; k < 2; k++) wb_data[k] = 32'(nv[k]);
      tick();
    end
    apply_stimulus(1'b0, MODE_STEP, 16'd0, 1'b0, 32'h0, 1'b0);
    tick();
    ok0 = (pop0.size() == 20);
    for (int j = 0; j < pop0.size(); j++) if (pop0[j] !== 32'(j + 1)) ok0 = 1'b0;
    ok1 = (pop1.size() == 16);
    for (int j = 0; j < pop1.size(); j++) if (pop1[j] !== 32'(j + 5)) ok1 = 1'b0;
    check("pop_count", 0, pop0.size(), 32'd20);
    check("pop_seq_1_to_20", 0, 32'(ok0), 32'd1);
    check("pop_count", 1, pop1.size(), 32'd16);
    check("pop_seq_5_to_20", 1, 32'(ok1), 32'd1);
    for (int k = 0; k < 2; k++) check("drained_empty", k, 32'(trace_empty[k]), 32'd1);

    // Asynchronous reset in the middle of RUN_N 100
    apply_stimulus(1'b1, MODE_RUN_N, 16'd100, 1'b1, 32'h5A5A, 1'b0);
    tick();
    apply_stimulus(1'b0, MODE_STEP, 16'd0, 1'b1, 32'h5A5A, 1'b0);
    repeat (39) tick();
    for (int k = 0; k < 2; k++) check("pre_reset_busy", k, 32'(busy[k]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("async_pipe_en", k, 32'(pipe_en[k]), 32'd0);
      check("async_busy", k, 32'(busy[k]), 32'd0);
      check("async_empty", k, 32'(trace_empty[k]), 32'd1);
      check("async_cycles", k, 32'(cycle_count[k]), 32'd0);
      check("async_overflow", k, 32'(overflow[k]), 32'd0);
    end
    model_reset();
    apply_stimulus(1'b0, MODE_STEP, 16'd0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    apply_stimulus(1'b1, MODE_STEP, 16'd0, 1'b1, 32'h77, 1'b0);
    tick();
    apply_stimulus(1'b0, MODE_STEP, 16'd0, 1'b1, 32'h77, 1'b0);
    tick();
    apply_stimulus(1'b0, MODE_STEP, 16'd0, 1'b0, 32'h0, 1'b0);
    repeat (2) tick();
    for (int k = 0; k < 2; k++) check("post_reset_data", k, trace_data[k], 32'h77);

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
